multiplier_seq_n: RTL and testbench

Parametrised sequential shift-add multiplier: WIDTH-bit multiplicand S (switches) times WIDTH-bit multiplier held in register B, producing a 2·WIDTH-bit product in A:B plus sign-extension bit X. It is the generalised successor of the lab 8-bit signed multiplier and keeps the same user controls (ClearA_LoadB, Run, S). It adds width scaling, Run edge detection, Busy/Done status and an optional unsigned mode. It sits between the switch/button synchronisers and the hex display drivers.

---
 rtl/multiplier_seq_n_if.sv | 37 +++
 rtl/multiplier_seq_n.sv | 141 ++++++++++++++
 tb/tb_multiplier_seq_n.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_seq_n_if.sv
// Handshake/data bundle for multiplier_seq_n: user controls in, product and status out.
// The Unsigned control only exists when MULT_UNSIGNED_MODE_EN is defined.
interface multiplier_seq_n_if #(
  parameter int WIDTH = 8
);
  logic             i_clear_a_load_b;
  logic             i_run;
  logic [WIDTH-1:0] i_s;
`ifdef MULT_UNSIGNED_MODE_EN
  logic             i_unsigned;
`endif
  logic [WIDTH-1:0] o_aval;
  logic [WIDTH-1:0] o_bval;
  logic             o_x;
  logic             o_busy;
  logic             o_done;

`ifdef MULT_UNSIGNED_MODE_EN
  modport master (
    output i_clear_a_load_b, i_run, i_s, i_unsigned,
    input  o_aval, o_bval, o_x, o_busy, o_done
  );
  modport slave (
    input  i_clear_a_load_b, i_run, i_s, i_unsigned,
    output o_aval, o_bval, o_x, o_busy, o_done
  );
`else
  modport master (
    output i_clear_a_load_b, i_run, i_s,
    input  o_aval, o_bval, o_x, o_busy, o_done
  );
  modport slave (
    input  i_clear_a_load_b, i_run, i_s,
    output o_aval, o_bval, o_x, o_busy, o_done
  );
`endif
endinterface

// File: rtl/multiplier_seq_n.sv
// Sequential shift-add multiplier: {X,A,B} <- B * S over WIDTH cycles, signed by default.
// Optional unsigned mode enabled by defining MULT_UNSIGNED_MODE_EN.
module multiplier_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  multiplier_seq_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_b_next;
  logic             r_x;
  logic             w_x_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_run_q;
  logic             w_mode_uns;
  logic             w_run_edge;
  logic             w_last;
  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:0]   w_sum;

`ifdef MULT_UNSIGNED_MODE_EN
  logic r_uns;
  logic w_uns_next;
  assign w_mode_uns = r_uns;
`else
  assign w_mode_uns = 1'b0;
`endif

  assign w_run_edge = bus.i_run & ~r_run_q;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // Signed mode carries the sign in X; the final multiplier bit has negative weight.
  assign w_acc   = w_mode_uns ? {1'b0, r_a} : {r_x, r_a};
  assign w_s_ext = w_mode_uns ? {1'b0, bus.i_s} : {bus.i_s[WIDTH-1], bus.i_s};

  always_comb begin
    w_sum = w_acc;
    if (r_b[0]) begin
      if (w_last && !w_mode_uns) begin
        w_sum = w_acc - w_s_ext;
      end else begin
        w_sum = w_acc + w_s_ext;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_x_next     = r_x;
    w_cnt_next   = r_cnt;
`ifdef MULT_UNSIGNED_MODE_EN
    w_uns_next   = r_uns;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_run_edge) begin
          w_state_next = S_COMPUTE;
          w_a_next     = '0;
          w_x_next     = 1'b0;
          w_cnt_next   = '0;
`ifdef MULT_UNSIGNED_MODE_EN
          w_uns_next   = bus.i_unsigned;
`endif
        end else if (bus.i_clear_a_load_b) begin
          w_b_next = bus.i_s;
          w_a_next = '0;
          w_x_next = 1'b0;
        end
      end
      S_COMPUTE: begin
        // Shift right by one: the sum MSB refills A (arithmetic in signed mode, carry in unsigned).
        w_a_next   = w_sum[WIDTH:1];
        w_b_next   = {w_sum[0], r_b[WIDTH-1:1]};
        w_x_next   = w_mode_uns ? 1'b0 : w_sum[WIDTH];
        w_cnt_next = r_cnt + CW'(1);
        if (w_last) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!bus.i_run) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= 1'b0;
      r_cnt   <= '0;
      r_run_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_x     <= w_x_next;
      r_cnt   <= w_cnt_next;
      r_run_q <= bus.i_run;
    end
  end

`ifdef MULT_UNSIGNED_MODE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_uns <= 1'b0;
    end else begin
      r_uns <= w_uns_next;
    end
  end
`endif

  assign bus.o_aval = r_a;
  assign bus.o_bval = r_b;
  assign bus.o_x    = r_x;
  assign bus.o_busy = (r_state == S_COMPUTE);
  assign bus.o_done = (r_state == S_HOLD);
endmodule

// File: tb/tb_multiplier_seq_n.sv
// Directed-vector bench for multiplier_seq_n at WIDTH=8 and WIDTH=16.
module tb_multiplier_seq_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt;

  always #5 clk = ~clk;

  multiplier_seq_n_if #(.WIDTH(8))  if8 ();
  multiplier_seq_n_if #(.WIDTH(16)) if16 ();

  multiplier_seq_n #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if8.slave)
  );

  multiplier_seq_n #(.WIDTH(16)) dut16 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if16.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] b);
    if8.i_clear_a_load_b = 1'b1;
    if8.i_s = b;
    tick();
    if8.i_clear_a_load_b = 1'b0;
  endtask

  task automatic wait_done8(input string tag, output int nbusy);
    logic got_done;
    got_done = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 30 && !got_done; i++) begin
      if (if8.o_busy) nbusy++;
      if (if8.o_done) got_done = 1'b1;
      else tick();
    end
    check_val({tag, "_done"}, 64'(if8.o_done), 64'd1);
  endtask

  // Raises Run and waits for Done; Run is left high for the caller to release.
  task automatic run8(input string tag);
    if8.i_run = 1'b1;
    tick();
    wait_done8(tag, busy_cnt);
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
  endtask

  task automatic release8();
    if8.i_run = 1'b0;
    tick();
  endtask

  task automatic check_res8(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic ex);
    check_val({tag, "_A"}, 64'(if8.o_aval), 64'(ea));
    check_val({tag, "_B"}, 64'(if8.o_bval), 64'(eb));
    check_val({tag, "_X"}, 64'(if8.o_x), 64'(ex));
  endtask

  task automatic check_zero8(input string tag);
    check_val({tag, "_AB"}, 64'({if8.o_aval, if8.o_bval}), 64'd0);
    check_val({tag, "_X_busy_done"}, 64'({if8.o_x, if8.o_busy, if8.o_done}), 64'd0);
  endtask

  initial begin
    if8.i_clear_a_load_b = 1'b0;
    if8.i_run = 1'b0;
    if8.i_s = '0;
    if16.i_clear_a_load_b = 1'b0;
    if16.i_run = 1'b0;
    if16.i_s = '0;
`ifdef MULT_UNSIGNED_MODE_EN
    if8.i_unsigned = 1'b0;
    if16.i_unsigned = 1'b0;
`endif
    #12;
    check_zero8("reset");
    check_val("reset16", 64'({if16.o_aval, if16.o_bval, if16.o_x, if16.o_busy, if16.o_done}), 64'd0);
    rst_n = 1'b1;
    tick();

    // -59 * 7 = -413
    load8(8'hC5);
    check_val("load_B", 64'(if8.o_bval), 64'hC5);
    if8.i_s = 8'h07;
    run8("m59x7");
    check_res8("m59x7", 8'hFE, 8'h63, 1'b1);
    check_val("m59x7_busy_low", 64'(if8.o_busy), 64'd0);
    release8();
    check_val("idle_done_low", 64'(if8.o_done), 64'd0);

    // 4 * 3 after a fresh reset
    rst_n = 1'b0;
    #1;
    check_zero8("reset2");
    rst_n = 1'b1;
    tick();
    load8(8'h04);
    if8.i_s = 8'h03;
    run8("4x3");
    check_res8("4x3", 8'h00, 8'h0C, 1'b0);

    // Chain: 12 * 3 = 36
    release8();
    if8.i_s = 8'h03;
    run8("chain");
    check_res8("chain", 8'h00, 8'h24, 1'b0);

    // Held Run does not restart
    for (int i = 0; i < 40; i++) tick();
    check_val("held_done", 64'(if8.o_done), 64'd1);
    check_val("held_busy", 64'(if8.o_busy), 64'd0);
    check_val("held_B", 64'(if8.o_bval), 64'h24);

    // ClearA_LoadB while busy and in HOLD is ignored: 36 * 3 = 108
    release8();
    if8.i_s = 8'h03;
    if8.i_run = 1'b1;
    tick();
    check_val("start_busy", 64'(if8.o_busy), 64'd1);
    if8.i_clear_a_load_b = 1'b1;
    tick();
    tick();
    if8.i_clear_a_load_b = 1'b0;
    wait_done8("clr_busy", busy_cnt);
    check_res8("clr_busy", 8'h00, 8'h6C, 1'b0);
    if8.i_clear_a_load_b = 1'b1;
    if8.i_s = 8'hFF;
    tick();
    if8.i_clear_a_load_b = 1'b0;
    check_val("clr_hold_B", 64'(if8.o_bval), 64'h6C);
    release8();

    // Run edge wins over ClearA_LoadB: 5 * 3 = 15
    load8(8'h05);
    if8.i_s = 8'h03;
    if8.i_clear_a_load_b = 1'b1;
    if8.i_run = 1'b1;
    tick();
    if8.i_clear_a_load_b = 1'b0;
    wait_done8("prio", busy_cnt);
    check_res8("prio", 8'h00, 8'h0F, 1'b0);
    release8();

    // -59 * -7 = 413, -128 * -128 = 16384, 127 * 127 = 16129
    load8(8'hC5);
    if8.i_s = 8'hF9;
    run8("neg_neg");
    check_res8("neg_neg", 8'h01, 8'h9D, 1'b0);
    release8();
    load8(8'h80);
    if8.i_s = 8'h80;
    run8("min_min");
    check_res8("min_min", 8'h40, 8'h00, 1'b0);
    release8();
    load8(8'h7F);
    if8.i_s = 8'h7F;
    run8("max_max");
    check_res8("max_max", 8'h3F, 8'h01, 1'b0);
    release8();

    // Reset during the third COMPUTE cycle
    load8(8'h6C);
    if8.i_s = 8'h03;
    if8.i_run = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero8("mid_reset");
    if8.i_run = 1'b0;
    rst_n = 1'b1;
    tick();
    run8("after_reset");
    check_res8("after_reset", 8'h00, 8'h00, 1'b0);
    release8();

`ifdef MULT_UNSIGNED_MODE_EN
    load8(8'hFF);
    if8.i_s = 8'hFF;
    if8.i_unsigned = 1'b1;
    run8("uns_ff");
    check_res8("uns_ff", 8'hFE, 8'h01, 1'b0);
    release8();
    load8(8'hFF);
    if8.i_s = 8'hFF;
    if8.i_unsigned = 1'b0;
    run8("sgn_ff");
    check_res8("sgn_ff", 8'h00, 8'h01, 1'b0);
    release8();
`endif

    // WIDTH=16: -59 * 7 with sign-extended operands
    if16.i_clear_a_load_b = 1'b1;
    if16.i_s = 16'hFFC5;
    tick();
    if16.i_clear_a_load_b = 1'b0;
    if16.i_s = 16'h0007;
    if16.i_run = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 40 && !if16.o_done; i++) begin
      if (if16.o_busy) busy_cnt++;
      tick();
    end
    check_val("w16_busy_cycles", 64'(busy_cnt), 64'd16);
    check_val("w16_done", 64'(if16.o_done), 64'd1);
    check_val("w16_AB", 64'({if16.o_aval, if16.o_bval}), 64'hFFFF_FE63);
    check_val("w16_X", 64'(if16.o_x), 64'd1);
    if16.i_run = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
